// File: rtl/bht_update_ctrl.sv
// Write-port controller for the 64-entry 4-way branch history table: arbitrates
// EXE counter updates, buffered ID allocations and a full-table invalidate sweep.
module bht_update_ctrl #(
  parameter int unsigned ALLOC_DEPTH = 2,
  parameter logic [1:0]  CTR_INIT_B  = 2'b10,
  parameter logic [1:0]  CTR_INIT_J  = 2'b11
) (
  input  logic        CLK,
  input  logic        rst,
  input  logic        clear_req,
  input  logic        id_alloc_valid,
  input  logic        id_hit,
  input  logic        id_is_jump,
  input  logic [9:0]  id_PC,
  input  logic [9:0]  id_target,
  input  logic        exe_upd_valid,
  input  logic [3:0]  exe_set,
  input  logic [1:0]  exe_way,
  input  logic [1:0]  exe_ctr,
  input  logic        exe_taken,
  output logic        wr_en,
  output logic [5:0]  wr_addr,
  output logic [18:0] wr_data,
  output logic        wr_ctr_only,
  output logic        busy,
  output logic        alloc_drop
);

  localparam int AW = $clog2(ALLOC_DEPTH);

  typedef enum logic {S_IDLE = 1'b0, S_CLEAR = 1'b1} state_t;

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic [5:0]              r_sweep;
  logic [1:0]              r_ptr [16];
  logic [ALLOC_DEPTH-1:0]  r_buf_vld;
  logic [AW-1:0]           r_rd;
  logic [AW-1:0]           r_wr;
  logic [9:0]              r_buf_pc  [ALLOC_DEPTH];
  logic [9:0]              r_buf_tgt [ALLOC_DEPTH];
  logic                    r_buf_jmp [ALLOC_DEPTH];

  logic        w_alloc_req;
  logic        w_dup;
  logic        w_empty;
  logic        w_full;
  logic        w_wr_en;
  logic [5:0]  w_wr_addr;
  logic [18:0] w_wr_data;
  logic        w_wr_ctr_only;
  logic        w_busy;
  logic        w_drop;
  logic        w_deq;
  logic        w_enq;
  logic        w_flush;
  logic        w_direct;
  logic        w_ptr_clr;
  logic        w_ptr_inc;
  logic [3:0]  w_ptr_set;
  logic [9:0]  w_al_pc;
  logic [9:0]  w_al_tgt;
  logic        w_al_jmp;

  function automatic logic [1:0] f_sat_ctr(input logic [1:0] ctr, input logic taken);
    if (taken) return (ctr == 2'b11) ? ctr : ctr + 2'd1;
    else       return (ctr == 2'b00) ? ctr : ctr - 2'd1;
  endfunction

  function automatic logic [AW-1:0] f_buf_inc(input logic [AW-1:0] p);
    return (p == AW'(ALLOC_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign w_alloc_req = id_alloc_valid & ~id_hit;
  assign w_empty     = ~r_buf_vld[r_rd];
  assign w_full      = r_buf_vld[r_wr];
  assign w_ptr_set   = w_al_pc[3:0];

  // A PC already waiting in the buffer (including the head leaving this cycle) is not queued twice.
  always_comb begin
    w_dup = 1'b0;
    for (int i = 0; i < ALLOC_DEPTH; i++) begin
      if (r_buf_vld[i] && (r_buf_pc[i] == id_PC)) w_dup = 1'b1;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_wr_en       = 1'b0;
    w_wr_addr     = '0;
    w_wr_data     = '0;
    w_wr_ctr_only = 1'b0;
    w_busy        = 1'b0;
    w_drop        = 1'b0;
    w_deq         = 1'b0;
    w_enq         = 1'b0;
    w_flush       = 1'b0;
    w_direct      = 1'b0;
    w_ptr_clr     = 1'b0;
    w_ptr_inc     = 1'b0;
    w_al_pc       = r_buf_pc[r_rd];
    w_al_tgt      = r_buf_tgt[r_rd];
    w_al_jmp      = r_buf_jmp[r_rd];
    case (r_state)
      S_IDLE: begin
        if (clear_req) begin
          w_state_nxt = S_CLEAR;
          w_flush     = 1'b1;
          w_ptr_clr   = 1'b1;
        end else begin
          if (exe_upd_valid) begin
            w_wr_en       = 1'b1;
            w_wr_addr     = {exe_set, exe_way};
            w_wr_data     = {17'd0, f_sat_ctr(exe_ctr, exe_taken)};
            w_wr_ctr_only = 1'b1;
          end else if (!w_empty) begin
            w_deq     = 1'b1;
            w_ptr_inc = 1'b1;
          end else if (w_alloc_req) begin
            w_direct  = 1'b1;
            w_ptr_inc = 1'b1;
            w_al_pc   = id_PC;
            w_al_tgt  = id_target;
            w_al_jmp  = id_is_jump;
          end
          if (w_ptr_inc) begin
            w_wr_en   = 1'b1;
            w_wr_addr = {w_al_pc[3:0], r_ptr[w_al_pc[3:0]]};
            w_wr_data = {1'b1, w_al_pc[9:4], w_al_tgt, (w_al_jmp ? CTR_INIT_J : CTR_INIT_B)};
          end
          // A full buffer still accepts when its head drains this same cycle.
          if (w_alloc_req && !w_direct && !w_dup) begin
            if (!w_full || w_deq) w_enq  = 1'b1;
            else                  w_drop = 1'b1;
          end
        end
      end
      S_CLEAR: begin
        w_wr_en   = 1'b1;
        w_wr_addr = r_sweep;
        w_busy    = 1'b1;
        w_ptr_clr = 1'b1;
        if (r_sweep == 6'd63) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_sweep     <= '0;
      r_buf_vld   <= '0;
      r_rd        <= '0;
      r_wr        <= '0;
      for (int i = 0; i < 16; i++) r_ptr[i] <= '0;
      wr_en       <= 1'b0;
      wr_addr     <= '0;
      wr_data     <= '0;
      wr_ctr_only <= 1'b0;
      busy        <= 1'b0;
      alloc_drop  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_sweep <= (r_state == S_CLEAR) ? r_sweep + 6'd1 : 6'd0;
      if (w_ptr_clr) begin
        for (int i = 0; i < 16; i++) r_ptr[i] <= '0;
      end else if (w_ptr_inc) begin
        r_ptr[w_ptr_set] <= r_ptr[w_ptr_set] + 2'd1;
      end
      if (w_flush) begin
        r_buf_vld <= '0;
        r_rd      <= '0;
        r_wr      <= '0;
      end else begin
        if (w_deq) begin
          r_buf_vld[r_rd] <= 1'b0;
          r_rd            <= f_buf_inc(r_rd);
        end
        if (w_enq) begin
          r_buf_vld[r_wr] <= 1'b1;
          r_wr            <= f_buf_inc(r_wr);
        end
      end
      wr_en       <= w_wr_en;
      wr_addr     <= w_wr_addr;
      wr_data     <= w_wr_data;
      wr_ctr_only <= w_wr_ctr_only;
      busy        <= w_busy;
      alloc_drop  <= w_drop;
    end
  end

  always_ff @(posedge CLK) begin
    if (w_enq) begin
      r_buf_pc[r_wr]  <= id_PC;
      r_buf_tgt[r_wr] <= id_target;
      r_buf_jmp[r_wr] <= id_is_jump;
    end
  end

endmodule
